serial_addsub: RTL

Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's combinational half/full adder and subtractor cells. One operand pair is latched on a start request, then one bit per clock is processed LSB-first through a single full add/sub cell. The block reports the result, the final carry or borrow, and signed overflow with a done pulse. It is intended for area-constrained datapaths where a WIDTH-bit ripple adder is not wanted.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/fa_fs_bit.sv | 28 ++
 rtl/serial_addsub.sv | 105 ++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Brief    : Shared state encoding and mode constants for the serial add/sub.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fa_fs_bit.sv
`default_nettype none
// ============================================================================
// Module   : fa_fs_bit
// Brief    : Combinational one-bit full adder / full subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module fa_fs_bit
   import addsub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic mode,
   output logic s,
   output logic cout
);

   logic w_x;

   assign w_x = a ^ b;
   assign s   = w_x ^ cin;

   // cin doubles as borrow-in; cout is carry-out for add, borrow-out for sub
   assign cout = (mode == MODE_SUB) ? ((~a & b) | (cin & ~w_x))
                                    : ((a & b)  | (cin & w_x));

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Brief    : Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit/clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a_sr, r_b_sr;
   logic             r_a_msb, r_b_msb, r_mode, r_c;
   logic [CW-1:0]    r_cnt;
   logic             w_accept, w_last, w_s, w_cout, w_ovf;

   fa_fs_bit u_cell (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_c),
      .mode (r_mode),
      .s    (w_s),
      .cout (w_cout)
   );

   assign w_accept = start && (r_state != RUN);
   assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

   // w_s is the result MSB on the final bit, so overflow resolves on that edge
   assign w_ovf = (r_mode == MODE_ADD) ? ((r_a_msb == r_b_msb) && (w_s != r_a_msb))
                                       : ((r_a_msb != r_b_msb) && (w_s != r_a_msb));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_mode   <= MODE_ADD;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (w_accept) begin
         r_a_sr   <= a;
         r_b_sr   <= b;
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
         r_mode   <= mode;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (r_state == RUN) begin
         r_a_sr <= r_a_sr >> 1;
         r_b_sr <= r_b_sr >> 1;
         r_c    <= w_cout;
         r_cnt  <= r_cnt + CW'(1);
         result <= {w_s, result[WIDTH-1:1]};
         if (w_last) begin
            cout     <= w_cout;
            overflow <= w_ovf;
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

endmodule
`default_nettype wire
